// File: rtl/retire_rat_pkg.sv
// Shared sizes, retire packet type and reset-value helpers for the RRAT.
package retire_rat_pkg;

  localparam int N                  = 4;
  localparam int RAT_SIZE           = 32;
  localparam int PRF_NUM_ENTRIES    = 64;
  localparam int PRF_NUM_INDEX_BITS = 6;
  localparam int ARCH_BITS          = 5;

  typedef logic [PRF_NUM_INDEX_BITS-1:0] prf_idx_t;
  typedef logic [ARCH_BITS-1:0]          arch_idx_t;
  typedef logic [PRF_NUM_ENTRIES-1:0]    prf_vec_t;
  typedef prf_idx_t [RAT_SIZE-1:0]       rat_t;

  typedef struct packed {
    logic      valid;
    arch_idx_t arch_reg_dest;
    prf_idx_t  phys_reg_dest;
  } retire_packet_t;

  // Identity mapping: architectural register i lives in physical register i.
  function automatic rat_t rrat_reset_map();
    rat_t m;
    for (int i = 0; i < RAT_SIZE; i++) begin
      m[i] = prf_idx_t'(i);
    end
    return m;
  endfunction

  // Physical registers above the architectural range start out free.
  function automatic prf_vec_t rrat_reset_free();
    prf_vec_t f;
    for (int i = 0; i < PRF_NUM_ENTRIES; i++) begin
      f[i] = (i >= RAT_SIZE);
    end
    return f;
  endfunction

endpackage

// File: rtl/retire_rat_if.sv
// Retirement input bundle and committed-state outputs of the RRAT.
interface retire_rat_if;
  import retire_rat_pkg::*;

  retire_packet_t [N-1:0] retire_packet_in;
  rat_t                   rrat_entries;
  prf_vec_t               rrat_free_list;
  prf_vec_t               free_vector_from_rrat;
  logic                   rrat_error;

  // Retire stage / id_stage side.
  modport master (
    output retire_packet_in,
    input  rrat_entries,
    input  rrat_free_list,
    input  free_vector_from_rrat,
    input  rrat_error
  );

  // RRAT side.
  modport slave (
    input  retire_packet_in,
    output rrat_entries,
    output rrat_free_list,
    output free_vector_from_rrat,
    output rrat_error
  );
endinterface

// File: rtl/retire_rat_merge.sv
// Combinational merge of up to N in-order retirements into the committed
// mapping and free list. Slots are walked oldest first against a running
// copy, so same-arch chains and free/claim overlaps resolve naturally.
module retire_rat_merge
  import retire_rat_pkg::*;
(
  input  rat_t                   i_map,
  input  prf_vec_t               i_free,
  input  retire_packet_t [N-1:0] i_pkts,
  output rat_t                   o_map,
  output prf_vec_t               o_free,
  output prf_vec_t               o_freed,
  output logic                   o_err
);

  // Sequential walk over the retire slots, oldest (slot 0) first.
  always_comb begin
    o_map   = i_map;
    o_free  = i_free;
    o_freed = '0;
    o_err   = 1'b0;
    for (int s = 0; s < N; s++) begin
      if (i_pkts[s].valid && (i_pkts[s].arch_reg_dest != '0)) begin
        // Claiming a register that is still committed and was not released
        // earlier in this group indicates a broken allocator upstream; the
        // update is applied anyway so state keeps tracking retirement.
        if (!o_free[i_pkts[s].phys_reg_dest] && !o_freed[i_pkts[s].phys_reg_dest]) begin
          o_err = 1'b1;
        end
        o_free[o_map[i_pkts[s].arch_reg_dest]]  = 1'b1;
        o_freed[o_map[i_pkts[s].arch_reg_dest]] = 1'b1;
        o_free[i_pkts[s].phys_reg_dest]         = 1'b0;
        o_map[i_pkts[s].arch_reg_dest]          = i_pkts[s].phys_reg_dest;
      end
    end
  end

endmodule

// File: rtl/retire_rat.sv
// Retirement register alias table: committed arch->phys mapping, committed
// free list, per-cycle freed pulse vector and a sticky protocol error flag.
module retire_rat
  import retire_rat_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  retire_rat_if.slave  bus
);

  rat_t     r_map;
  prf_vec_t r_free;
  prf_vec_t r_freed;
  logic     r_err;

  rat_t     w_map_next;
  prf_vec_t w_free_next;
  prf_vec_t w_freed_next;
  logic     w_err_pulse;

  retire_rat_merge u_merge (
    .i_map   (r_map),
    .i_free  (r_free),
    .i_pkts  (bus.retire_packet_in),
    .o_map   (w_map_next),
    .o_free  (w_free_next),
    .o_freed (w_freed_next),
    .o_err   (w_err_pulse)
  );

  // Commit the merged state; reset discards any concurrent retire group.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_map   <= rrat_reset_map();
      r_free  <= rrat_reset_free();
      r_freed <= '0;
      r_err   <= 1'b0;
    end else begin
      r_map   <= w_map_next;
      r_free  <= w_free_next;
      r_freed <= w_freed_next;
      r_err   <= r_err | w_err_pulse;
    end
  end

  assign bus.rrat_entries          = r_map;
  assign bus.rrat_free_list        = r_free;
  assign bus.free_vector_from_rrat = r_freed;
  assign bus.rrat_error            = r_err;

endmodule

// File: doc/retire_rat.md
# retire_rat

Retirement register alias table (RRAT) for the N-wide out-of-order core. It holds the committed architectural-to-physical register mapping and the committed PRF free list. It updates both from up to `N in-order retirements per cycle. It drives `rrat_entries`, `rrat_free_list` and `free_vector_from_rrat` into `id_stage`, which restores its speculative RAT and free list from them on `nuke` and reclaims freed physical registers every cycle.

## Interface
Parameters (global sys_defs macros, not module parameters):
- `N`, 4: retire and dispatch width.
- `RAT_SIZE`, 32: architectural registers.
- `PRF_NUM_ENTRIES`, 64: physical registers.
- `PRF_NUM_INDEX_BITS`, 6: PRF index width.

Ports:
- `clock`  in  1: the only clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `retire_packet_in`  in  `N` x RETIRE_PACKET: per slot `valid`, `arch_reg_dest` (5 bits), `phys_reg_dest` (`PRF_NUM_INDEX_BITS`). Slot 0 is the oldest instruction.
- `rrat_entries`  out  `RAT_SIZE` x `PRF_NUM_INDEX_BITS`: committed mapping, registered.
- `rrat_free_list`  out  `PRF_NUM_ENTRIES`: bit=1 means the physical register is not part of the committed state. Registered.
- `free_vector_from_rrat`  out  `PRF_NUM_ENTRIES`: physical registers released by last cycle's retirements. Registered, one-cycle pulse per bit.
- `rrat_error`  out  1: sticky protocol-violation flag.

## Operation
- Reset state (and the value of every output in the cycle after `reset` is sampled high):
  - `rrat_entries[i]=i`.
  - `rrat_free_list` = 1 for indices >= `RAT_SIZE`, 0 for indices < `RAT_SIZE`.
  - `free_vector_from_rrat=0`.
  - `rrat_error=0`.
- Each cycle, slots are processed sequentially from 0 to `N-1` against a running copy of the mapping. Slots that are not `valid` are skipped.
- A slot with `arch_reg_dest==0` is a no-op: no mapping change, no free. `id_stage` never allocates a physical register for x0.
- Otherwise, with old = running mapping of `arch_reg_dest` and new = `phys_reg_dest`:
  - mapping[arch] <- new;
  - free bit old <- 1 and freed bit old <- 1;
  - free bit new <- 0.
- Within one group, a younger write to the same arch register frees the older slot's new mapping, which chains naturally through the sequential model.
- If one index is both freed and claimed within the group, the later-processed slot's effect wins.
- Error detection: `rrat_error` sets when a valid non-x0 slot's new index is already committed, i.e. running free bit = 0 and not freed earlier in the same group. The update is still applied. The flag clears only on reset.
- Valid slots need not be contiguous; each valid slot is processed by index order.
- No nuke input. Mispredict recovery is `id_stage` copying these outputs. Retirements in the nuke cycle are still applied.

## Timing
- Latency: retirement at edge t is visible on all outputs after edge t; `id_stage` samples them in cycle t+1.
- `free_vector_from_rrat` is the freed set of the most recent edge only. It is 0 after any cycle with no effective retirement.
- `reset` overrides any concurrent retirement; that retire group is discarded.
- Next state is computed combinationally in one cycle for all `N` slots. There is no backpressure and no stall.

## Structure
- `RETIRE_PACKET` typedef and the size macros live in sys_defs, alongside `CDB` and `ID_EX_PACKET`.
- One combinational sub-module is natural: `rrat_retire_merge`. It takes the current mapping, the free list and the `N` packets, and returns the next mapping, the next free list, the freed vector and the error pulse. The top level holds the registers.

## Test plan
- Reset:
  - Stimulus: assert reset for 1 cycle.
  - Required response: `rrat_entries[i]=i`, `rrat_free_list=64'hFFFF_FFFF_0000_0000`, `free_vector_from_rrat=0`, `rrat_error=0`.
- Single retire:
  - Stimulus: slot0 valid, arch 5, phys 40.
  - Required response: `entries[5]=40`; free bit 40=0 and bit 5=1; `free_vector_from_rrat` has only bit 5 set; it returns to 0 the following idle cycle.
- Same-arch chain:
  - Stimulus: slot0 arch 7->33, slot1 arch 7->34.
  - Required response: `entries[7]=34`; `free_vector_from_rrat` bits {7,33} set; free bits 7,33=1 and 34=0.
- Full-width independent retire:
  - Stimulus: arch 1,2,3,4 -> phys 32,33,34,35.
  - Required response: all four mappings updated in one cycle; `free_vector_from_rrat` bits {1,2,3,4} set.
- x0 and invalid slots:
  - Stimulus: slot0 arch 0 phys 50; slot2 valid=0 arch 9 phys 51.
  - Required response: no change to the mapping or free list; `free_vector_from_rrat=0`.
- Error and reset priority:
  - Stimulus: retire arch 3 -> phys 10 (phys 10 is still committed for arch 10).
  - Required response: `rrat_error=1`, sticky; `entries[3]=10`.
  - Stimulus: then reset asserted together with a valid retire.
  - Required response: full reset state, `rrat_error=0`.
